// File: rtl/dmem_sb.sv
// rtl/dmem_sb.sv - data-memory responder with a FIFO store buffer in front of a word RAM
//
// Loads are answered combinationally from the RAM, or from the store buffer when
// forwarding is built in. Stores are queued and written to the RAM in cycles
// with no load. A full buffer forces a drain and raises mem_busy_o.
//
// Build option: define DMEM_SB_FWD_EN to forward pending stores to loads. When
// it is undefined, a load that hits a pending store raises mem_busy_o and forces
// drains until the hit is gone.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   mem_re_i, mem_raddr_i         load request and byte address
//   mem_we_i, mem_waddr_i,
//   mem_wdata_i                   store request, byte address and full word
//   mem_rdata_o                   load data (combinational)
//   mem_busy_o                    pipeline must hold
//   sb_empty_o, sb_count_o        store buffer occupancy
module dmem_sb #(
    parameter int ADDR_W   = 12,
    parameter int SB_DEPTH = 4,
    parameter int SB_PTR_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_re_i,
    input  logic [31:0]         mem_raddr_i,
    input  logic                mem_we_i,
    input  logic [31:0]         mem_waddr_i,
    input  logic [31:0]         mem_wdata_i,
    output logic [31:0]         mem_rdata_o,
    output logic                mem_busy_o,
    output logic                sb_empty_o,
    output logic [SB_PTR_W:0]   sb_count_o
);

    // RAM and buffer payload carry no reset: RAM contents must survive rst,
    // and buffer slots are only ever read behind a valid count.
    logic [31:0]          mem_q     [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0]    sb_idx_q  [SB_DEPTH];
    logic [31:0]          sb_data_q [SB_DEPTH];

    logic [SB_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [SB_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [SB_PTR_W:0]    count_q,  count_d;

    logic [ADDR_W-1:0]    ridx, widx;
    logic                 full;
    logic                 hit;
    logic                 enq, drain;
    logic [SB_PTR_W-1:0]  pos;

    logic                 unused_addr_bits;
    assign unused_addr_bits = ^{mem_raddr_i[31:ADDR_W+2], mem_raddr_i[1:0],
                                mem_waddr_i[31:ADDR_W+2], mem_waddr_i[1:0]};

    assign ridx = mem_raddr_i[ADDR_W+1:2];
    assign widx = mem_waddr_i[ADDR_W+1:2];
    assign full = (count_q == (SB_PTR_W+1)'(SB_DEPTH));

`ifdef DMEM_SB_FWD_EN
    logic [31:0] hit_data;

    // Walk oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        pos      = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            pos = rd_ptr_q + SB_PTR_W'(k);
            if ((SB_PTR_W+1)'(k) < count_q && sb_idx_q[pos] == ridx) begin
                hit      = 1'b1;
                hit_data = sb_data_q[pos];
            end
        end
    end

    assign mem_rdata_o = hit ? hit_data : mem_q[ridx];
    assign mem_busy_o  = full;
    assign drain       = (count_q != '0) && (!mem_re_i || full);
`else
    always_comb begin
        hit = 1'b0;
        pos = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            pos = rd_ptr_q + SB_PTR_W'(k);
            if ((SB_PTR_W+1)'(k) < count_q && sb_idx_q[pos] == ridx) begin
                hit = 1'b1;
            end
        end
    end

    // A load hitting a pending store must wait: stall it and push the
    // buffer out until the stale RAM word has been overwritten.
    assign mem_rdata_o = mem_q[ridx];
    assign mem_busy_o  = full || (mem_re_i && hit);
    assign drain       = (count_q != '0) && (!mem_re_i || full || hit);
`endif

    assign enq        = mem_we_i && !full;
    assign sb_empty_o = (count_q == '0);
    assign sb_count_o = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (drain) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (enq && !drain) begin
            count_d = count_q + 1'b1;
        end else if (drain && !enq) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Enqueue never targets the head slot while it drains: that would need a
    // full buffer, and a full buffer refuses stores.
    always_ff @(posedge clk) begin
        if (enq) begin
            sb_idx_q[wr_ptr_q]  <= widx;
            sb_data_q[wr_ptr_q] <= mem_wdata_i;
        end
        if (drain) begin
            mem_q[sb_idx_q[rd_ptr_q]] <= sb_data_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_dmem_sb.sv
// tb/tb_dmem_sb.sv - randomized bench for dmem_sb against a queue-based reference model
module tb_dmem_sb;

`ifdef DMEM_SB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int NW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_re_i = 1'b0;
    logic [31:0] mem_raddr_i = '0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_waddr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_busy_o;
    logic        sb_empty_o;
    logic [2:0]  sb_count_o;

    dmem_sb dut (
        .clk         (clk),
        .rst         (rst),
        .mem_re_i    (mem_re_i),
        .mem_raddr_i (mem_raddr_i),
        .mem_we_i    (mem_we_i),
        .mem_waddr_i (mem_waddr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_busy_o  (mem_busy_o),
        .sb_empty_o  (sb_empty_o),
        .sb_count_o  (sb_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } ent_t;

    ent_t        pend[$];
    logic [31:0] ref_mem [NW];
    bit          known   [NW];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Random junk in the ignored byte-offset and upper address bits.
    function automatic logic [31:0] mkaddr(input int idx);
        logic [31:0] a;
        a = $urandom & 32'hFFFF_C003;
        return a | (32'(idx) << 2);
    endfunction

    // One clock: drive at negedge, check combinational outputs, then apply the
    // buffer rules to the model at the following rising edge.
    task automatic cyc(input bit re, input int ridx, input bit we, input int widx,
                       input logic [31:0] wd);
        bit          full, hit, drain, enq;
        logic [31:0] hd;
        @(negedge clk);
        mem_re_i    = re;
        mem_raddr_i = mkaddr(ridx);
        mem_we_i    = we;
        mem_waddr_i = mkaddr(widx);
        mem_wdata_i = wd;
        #1;
        full = (pend.size() == 4);
        hit  = 1'b0;
        hd   = '0;
        foreach (pend[i]) begin
            if (pend[i].idx == ridx) begin
                hit = 1'b1;
                hd  = pend[i].data;
            end
        end
        check("count", 32'(sb_count_o), 32'(pend.size()));
        check("empty", 32'(sb_empty_o), 32'(pend.size() == 0));
        check("busy",  32'(mem_busy_o), 32'(full || (!FWD && re && hit)));
        if (re && !full && (FWD || !hit)) begin
            if (FWD && hit) begin
                check("rdata_fwd", mem_rdata_o, hd);
            end else if (known[ridx]) begin
                check("rdata_ram", mem_rdata_o, ref_mem[ridx]);
            end
        end
        drain = (pend.size() != 0) && (!re || full || (!FWD && hit));
        enq   = we && !full;
        @(posedge clk);
        if (drain) begin
            ref_mem[pend[0].idx] = pend[0].data;
            known[pend[0].idx]   = 1'b1;
            void'(pend.pop_front());
        end
        if (enq) begin
            pend.push_back('{idx: widx, data: wd});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 0, 32'h0);
    endtask

    // Reset asserted in the middle of the low phase; outputs must clear at once.
    task automatic pulse_reset();
        @(negedge clk);
        mem_re_i = 1'b0;
        mem_we_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_count", 32'(sb_count_o), 32'd0);
        check("rst_empty", 32'(sb_empty_o), 32'd1);
        check("rst_busy",  32'(mem_busy_o), 32'd0);
        pend.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        foreach (known[i]) known[i] = 1'b0;
        #12;
        pulse_reset();

        // Give every word in the test range a defined value.
        for (int i = 0; i < NW; i++) cyc(1'b0, 0, 1'b1, i, $urandom);
        idle(6);

        // Single store then readback.
        cyc(1'b0, 0, 1'b1, 4, 32'hDEAD_BEEF);
        idle(2);
        cyc(1'b1, 4, 1'b0, 0, 32'h0);
        check("deadbeef", mem_rdata_o, 32'hDEAD_BEEF);

        // Load held on 0x20 while two stores to it queue up.
        cyc(1'b1, 8, 1'b1, 8, 32'h11);
        cyc(1'b1, 8, 1'b1, 8, 32'h22);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8, 1'b0, 0, 32'h0);
        check("ld22", mem_rdata_o, 32'h22);
        idle(4);

        // Fill the buffer under a steady load, drop a fifth store, forced drain.
        for (int i = 1; i <= 5; i++) cyc(1'b1, 15, 1'b1, i, 32'hA000_0000 + 32'(i));
        cyc(1'b1, 15, 1'b0, 0, 32'h0);
        idle(5);

        // Enqueue and drain in the same cycle at count 2.
        cyc(1'b1, 15, 1'b1, 6, 32'h600);
        cyc(1'b1, 15, 1'b1, 7, 32'h700);
        cyc(1'b0, 0,  1'b1, 9, 32'h900);
        idle(4);

        // Pending stores are discarded by reset; RAM keeps its old words.
        for (int i = 12; i <= 14; i++) cyc(1'b1, 15, 1'b1, i, 32'hBAD0_0000 + 32'(i));
        pulse_reset();
        for (int i = 12; i <= 14; i++) cyc(1'b1, i, 1'b0, 0, 32'h0);

        // Random traffic on a narrow address window to provoke buffer hits.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    ($urandom_range(0, 9) < 6), int'($urandom_range(0, 7)), $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
